// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared NES bus types and constants for the sprite DMA path.
package nes_bus_pkg;
   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;
   localparam logic [15:0] OAMDMA_ADDR = 16'h4014;
   localparam int OAM_SIZE = 256;
endpackage

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: 2A03 sprite DMA, halts the CPU and copies page $XX00-$XXFF into PPU OAM.
// OAM_DMA_PARITY_EN adds the odd-cycle ALIGN stall; undefined gives a fixed 513-cycle hijack.
module oam_dma_ctrl
   import nes_bus_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR = OAMDMA_ADDR,
   parameter int XFER_LEN = OAM_SIZE
) (
   input  logic        Clk,
   input  logic        Res_n,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rw_n,
   input  logic [7:0]  cpu_do,
   input  logic [7:0]  bus_din,
   input  logic [7:0]  oam_base,
   output logic        dma_active,
   output logic [15:0] dma_addr,
   output logic        dma_rw_n,
   output logic        oam_we,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_wdata,
   output logic        dma_done
);
   localparam logic [7:0] LAST = 8'(XFER_LEN - 1);
   dma_state_t state;
   logic [7:0] page, base, index;
`ifdef OAM_DMA_PARITY_EN
   logic parity;
`endif
   assign dma_rw_n = 1'b1;
   always_ff @(posedge Clk or negedge Res_n) begin
      if (!Res_n) begin
         state      <= IDLE;
         page       <= 8'h00;
         base       <= 8'h00;
         index      <= 8'h00;
         dma_active <= 1'b0;
         dma_addr   <= 16'h0000;
         oam_we     <= 1'b0;
         oam_addr   <= 8'h00;
         oam_wdata  <= 8'h00;
         dma_done   <= 1'b0;
`ifdef OAM_DMA_PARITY_EN
         parity     <= 1'b0;
`endif
      end else begin
`ifdef OAM_DMA_PARITY_EN
         parity <= ~parity;
`endif
         oam_we   <= 1'b0;
         dma_done <= 1'b0;
         case (state)
            IDLE:
               if (!cpu_rw_n && cpu_addr == DMA_REG_ADDR) begin
                  page       <= cpu_do;
                  base       <= oam_base;
                  index      <= 8'h00;
                  dma_active <= 1'b1;
                  state      <= HALT;
               end
            HALT: begin
`ifdef OAM_DMA_PARITY_EN
               // An odd cycle costs one extra dummy read before the first real one
               if (parity) state <= ALIGN;
               else begin
                  state    <= READ;
                  dma_addr <= {page, index};
               end
`else
               state    <= READ;
               dma_addr <= {page, index};
`endif
            end
            ALIGN: begin
               state    <= READ;
               dma_addr <= {page, index};
            end
            READ: begin
               state     <= WRITE;
               oam_we    <= 1'b1;
               oam_addr  <= base + index;
               oam_wdata <= bus_din;
            end
            WRITE:
               if (index == LAST) begin
                  state      <= IDLE;
                  dma_active <= 1'b0;
                  dma_done   <= 1'b1;
               end else begin
                  index    <= index + 8'd1;
                  dma_addr <= {page, index + 8'd1};
                  state    <= READ;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences the 2A03 sprite DMA: a CPU write to $4014 halts the CPU and streams 256 bytes from page $XX00-$XXFF into PPU OAM.
- Drives the databus DMA hijack, which gates the CPU Enable, and the DMA address.
- Alternates bus read cycles with OAM write cycles.
- Sits between the CPU, the databus and the PPU OAM port, and is clocked on the CPU clock.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA
- XFER_LEN, 256, bytes per transfer; must be a power of two, at most 256

Ports:
- Clk  in  1  CPU clock (CLK_NES domain)
- Res_n  in  1  asynchronous active-low reset
- cpu_addr  in  16  CPU address bus (low 16 bits of T65 A)
- cpu_rw_n  in  1  CPU R/W, 0 = write
- cpu_do  in  8  CPU write data
- bus_din  in  8  databus read result during DMA read cycles
- oam_base  in  8  current PPU OAMADDR
- dma_active  out  1  hijack; CPU Enable = ~dma_active; databus selects dma_addr
- dma_addr  out  16  source address during DMA
- dma_rw_n  out  1  always 1 (DMA only reads the bus)
- oam_we  out  1  OAM write strobe
- oam_addr  out  8  OAM write index
- oam_wdata  out  8  OAM write data
- dma_done  out  1  one-cycle pulse after the final OAM write

Behaviour:
- Reset: all outputs are 0 (dma_rw_n = 1), state IDLE, parity = 0, index = 0.
- Parity flop:
  - Toggles every Clk from reset; parity = 1 denotes an odd CPU cycle.
  - Runs regardless of DMA state.
- Trigger:
  - Occurs in IDLE when cpu_rw_n = 0 and cpu_addr == DMA_REG_ADDR on a rising edge.
  - Latches page <= cpu_do and base <= oam_base.
  - Clears index; goes to HALT.
- States:
  - IDLE: dma_active = 0.
  - HALT: one cycle, dma_active = 1. Next state is ALIGN if parity = 1 at this edge, else READ.
  - ALIGN: one dummy cycle, then READ.
  - READ: dma_addr = {page, index}. Register byte <= bus_din at the end of the cycle, then go to WRITE.
  - WRITE:
    - oam_we = 1, oam_addr = base + index (mod 256, wraps), oam_wdata = byte.
    - If index == XFER_LEN-1: go to IDLE and pulse dma_done on the following cycle.
    - Otherwise index++ and go to READ.
- Latency: trigger edge to first READ is 1 cycle (even) or 2 cycles (odd).
- Total hijack duration: 513 cycles (even) or 514 cycles (odd).
- dma_active is registered. It asserts the cycle after the trigger and deasserts the cycle after the last WRITE.
- Writes to DMA_REG_ADDR while dma_active = 1 are ignored. The CPU is halted, so this case occurs only via test stimulus.
- A cpu_rw_n = 1 access to DMA_REG_ADDR never triggers.
- Arithmetic:
  - index is 8 bits.
  - OAM address addition is 8-bit with carry discarded. Example: base $F0 and index $20 give oam_addr $10.
- Reset mid-transfer: return immediately to reset values. No pending transfer resumes; OAM keeps any partial writes.
- dma_addr holds the last driven value when not in READ. This is don't-care when dma_active = 0.

Optional Feature:
- OAM_DMA_PARITY_EN
- Defined: ALIGN insertion on odd parity as above (513/514 cycles).
- Undefined:
  - The parity flop is removed; HALT always proceeds to READ.
  - Fixed 513-cycle hijack.
  - The ALIGN state is unreachable and may be omitted.

Decomposition:
- Package nes_bus_pkg holds:
  - the dma_state_t enum (IDLE, HALT, ALIGN, READ, WRITE)
  - the OAMDMA_ADDR constant 16'h4014
  - the OAM_SIZE constant 256
- No sub-module is required. The parity flop and index counter stay inline.

Test Plan:
- Write $02 to $4014 on even parity, oam_base $00, memory[$0200+i] = i^$A5:
  - dma_active high for exactly 513 cycles
  - 256 oam_we pulses with oam_addr i and data i^$A5
  - one dma_done pulse
- Same trigger on odd parity: first READ occurs 2 cycles after the trigger, total 514 cycles. With OAM_DMA_PARITY_EN undefined: 513 cycles.
- oam_base $F0, page $03: the write to source $0310 lands at oam_addr $00; the last write is at oam_addr $EF.
- Read of $4014, and write to $4015: no dma_active, no oam_we.
- Assert Res_n low at cycle 100 of a transfer:
  - all outputs 0 asynchronously
  - after release, idle until a new $4014 write
- Re-trigger ($07 to $4014) injected while dma_active: ignored; all 256 writes use page $02; a subsequent trigger after dma_done uses page $07.
